// File: rtl/hdmi_blk_pkg.sv
// rtl/hdmi_blk_pkg.sv - shared constants, pixel type and read FSM states for blocks_to_hdmi
package hdmi_blk_pkg;

  localparam int BLOCK_SIZE = 8;

  typedef struct packed {
    logic [7:0] cb;
    logic [7:0] cr;
    logic [7:0] y;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LINE,
    GAP
  } rd_state_e;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/strip_ram.sv
// rtl/strip_ram.sv - simple dual-port strip buffer, one write port, registered read port
module strip_ram #(
  parameter int WIDTH  = 48,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/blocks_to_hdmi.sv
// rtl/blocks_to_hdmi.sv - 8x8 block-ordered YCrCb stream to raster HDMI stream via ping-pong strip buffers
module blocks_to_hdmi
  import hdmi_blk_pkg::*;
#(
  parameter int N     = 2,
  parameter int X_RES = 2160,
  parameter int Y_RES = 1200,
  parameter int H_GAP = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           blk_valid,
  output logic           blk_ready,
  input  logic [N*8-1:0] blk_data_y,
  input  logic [N*8-1:0] blk_data_cr,
  input  logic [N*8-1:0] blk_data_cb,
  input  logic           blk_sob,
  input  logic           blk_eob,
  input  logic           blk_sof,
  output logic           hdmi_v_sync,
  output logic           hdmi_h_sync,
  output logic           hdmi_data_valid,
  output logic [N*8-1:0] hdmi_data_y,
  output logic [N*8-1:0] hdmi_data_cr,
  output logic [N*8-1:0] hdmi_data_cb
);

  localparam int EPB    = BLOCK_SIZE / N;
  localparam int CPL    = X_RES / N;
  localparam int NB     = X_RES / BLOCK_SIZE;
  localparam int DEPTH  = CPL * BLOCK_SIZE;
  localparam int AW     = clog2_min1(DEPTH);
  localparam int EW     = clog2_min1(EPB);
  localparam int BW     = clog2_min1(NB);
  localparam int CW     = clog2_min1(CPL);
  localparam int GW     = clog2_min1(H_GAP);
  localparam int LW     = clog2_min1(BLOCK_SIZE);
  localparam int PW     = N * 8;
  localparam int WORD_W = N * $bits(pixel_t);

  if ((BLOCK_SIZE % N) != 0 || (X_RES % BLOCK_SIZE) != 0 ||
      (Y_RES % BLOCK_SIZE) != 0 || H_GAP < 1) begin : g_param_check
    $error("blocks_to_hdmi: unsupported parameter set");
  end

  // Block boundaries are implied by the counters, so the sideband flags carry no extra information.
  logic unused_sideband;
  assign unused_sideband = blk_sob ^ blk_eob;

  logic [EW-1:0] elem_q, elem_d, elem_cur;
  logic [LW-1:0] wline_q, wline_d, wline_cur;
  logic [BW-1:0] wblk_q, wblk_d, wblk_cur;
  logic [1:0]    full_q, full_d;
  logic [1:0]    sof_q, sof_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic          ready_int, accept, strip_done, release_buf;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [WORD_W-1:0] wr_word, rd_word0, rd_word1, rd_word;

  rd_state_e     state_q, state_d;
  logic [LW-1:0] rline_q, rline_d;
  logic [CW-1:0] col_q, col_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          hs_d, vs_d, rd_en;

  logic          hs_p1_q, vs_p1_q, vld_p1_q, sel_p1_q;
  logic          hs_out_q, vs_out_q, vld_out_q;
  logic [PW-1:0] y_out_q, y_out_d, cr_out_q, cr_out_d, cb_out_q, cb_out_d;

  always_comb begin
    ready_int  = en && !full_q[wr_sel_q];
    accept     = blk_valid && ready_int;
    elem_cur   = blk_sof ? '0 : elem_q;
    wline_cur  = blk_sof ? '0 : wline_q;
    wblk_cur   = blk_sof ? '0 : wblk_q;
    wr_addr    = AW'(elem_cur) + AW'(wline_cur * CPL) + AW'(wblk_cur * EPB);
    wr_word    = {blk_data_cb, blk_data_cr, blk_data_y};
    strip_done = accept && (elem_cur == EW'(EPB - 1)) &&
                 (wline_cur == LW'(BLOCK_SIZE - 1)) && (wblk_cur == BW'(NB - 1));
    elem_d     = elem_q;
    wline_d    = wline_q;
    wblk_d     = wblk_q;
    if (accept) begin
      elem_d  = elem_cur + 1'b1;
      wline_d = wline_cur;
      wblk_d  = wblk_cur;
      if (elem_cur == EW'(EPB - 1)) begin
        elem_d = '0;
        if (wline_cur == LW'(BLOCK_SIZE - 1)) begin
          wline_d = '0;
          wblk_d  = (wblk_cur == BW'(NB - 1)) ? '0 : wblk_cur + 1'b1;
        end else begin
          wline_d = wline_cur + 1'b1;
        end
      end
    end
    wr_sel_d = wr_sel_q ^ strip_done;
  end

  always_comb begin
    state_d     = state_q;
    rline_d     = rline_q;
    col_d       = col_q;
    gap_d       = gap_q;
    hs_d        = 1'b0;
    vs_d        = 1'b0;
    rd_en       = 1'b0;
    release_buf = 1'b0;
    rd_sel_d    = rd_sel_q;
    case (state_q)
      IDLE: begin
        if (en && full_q[rd_sel_q]) begin
          state_d = SYNC;
          rline_d = '0;
        end
      end
      SYNC: begin
        hs_d    = 1'b1;
        vs_d    = sof_q[rd_sel_q] && (rline_q == '0);
        col_d   = '0;
        state_d = LINE;
      end
      LINE: begin
        rd_en = 1'b1;
        if (col_q == CW'(CPL - 1)) begin
          gap_d   = '0;
          state_d = GAP;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GW'(H_GAP - 1)) begin
          if (rline_q == LW'(BLOCK_SIZE - 1)) begin
            state_d     = IDLE;
            release_buf = 1'b1;
            rd_sel_d    = ~rd_sel_q;
          end else begin
            rline_d = rline_q + 1'b1;
            state_d = SYNC;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_addr = AW'(rline_q * CPL) + AW'(col_q);
  end

  // Write-side completion and read-side release never target the same buffer in one cycle.
  always_comb begin
    full_d = full_q;
    sof_d  = sof_q;
    if (accept && blk_sof) begin
      sof_d[wr_sel_q] = 1'b1;
    end
    if (strip_done) begin
      full_d[wr_sel_q] = 1'b1;
    end
    if (release_buf) begin
      full_d[rd_sel_q] = 1'b0;
      sof_d[rd_sel_q]  = 1'b0;
    end
  end

  always_comb begin
    rd_word  = sel_p1_q ? rd_word1 : rd_word0;
    y_out_d  = vld_p1_q ? rd_word[PW-1:0]      : '0;
    cr_out_d = vld_p1_q ? rd_word[2*PW-1:PW]   : '0;
    cb_out_d = vld_p1_q ? rd_word[3*PW-1:2*PW] : '0;
  end

  strip_ram #(.WIDTH(WORD_W), .DEPTH(DEPTH), .ADDR_W(AW)) u_ram0 (
    .clk     (clk),
    .wr_en   (accept && !wr_sel_q),
    .wr_addr (wr_addr),
    .wr_data (wr_word),
    .rd_addr (rd_addr),
    .rd_data (rd_word0)
  );

  strip_ram #(.WIDTH(WORD_W), .DEPTH(DEPTH), .ADDR_W(AW)) u_ram1 (
    .clk     (clk),
    .wr_en   (accept && wr_sel_q),
    .wr_addr (wr_addr),
    .wr_data (wr_word),
    .rd_addr (rd_addr),
    .rd_data (rd_word1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_q    <= '0;
      wline_q   <= '0;
      wblk_q    <= '0;
      full_q    <= '0;
      sof_q     <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      state_q   <= IDLE;
      rline_q   <= '0;
      col_q     <= '0;
      gap_q     <= '0;
      hs_p1_q   <= 1'b0;
      vs_p1_q   <= 1'b0;
      vld_p1_q  <= 1'b0;
      sel_p1_q  <= 1'b0;
      hs_out_q  <= 1'b0;
      vs_out_q  <= 1'b0;
      vld_out_q <= 1'b0;
      y_out_q   <= '0;
      cr_out_q  <= '0;
      cb_out_q  <= '0;
    end else begin
      elem_q    <= elem_d;
      wline_q   <= wline_d;
      wblk_q    <= wblk_d;
      full_q    <= full_d;
      sof_q     <= sof_d;
      wr_sel_q  <= wr_sel_d;
      rd_sel_q  <= rd_sel_d;
      state_q   <= state_d;
      rline_q   <= rline_d;
      col_q     <= col_d;
      gap_q     <= gap_d;
      hs_p1_q   <= hs_d;
      vs_p1_q   <= vs_d;
      vld_p1_q  <= rd_en;
      sel_p1_q  <= rd_sel_q;
      hs_out_q  <= hs_p1_q;
      vs_out_q  <= vs_p1_q;
      vld_out_q <= vld_p1_q;
      y_out_q   <= y_out_d;
      cr_out_q  <= cr_out_d;
      cb_out_q  <= cb_out_d;
    end
  end

  assign blk_ready       = ready_int;
  assign hdmi_v_sync     = vs_out_q;
  assign hdmi_h_sync     = hs_out_q;
  assign hdmi_data_valid = vld_out_q;
  assign hdmi_data_y     = y_out_q;
  assign hdmi_data_cr    = cr_out_q;
  assign hdmi_data_cb    = cb_out_q;

endmodule

// File: tb/tb_blocks_to_hdmi.sv
// tb/tb_blocks_to_hdmi.sv - self-checking bench for blocks_to_hdmi
module tb_blocks_to_hdmi;

  localparam int N      = 2;
  localparam int X_RES  = 16;
  localparam int Y_RES  = 16;
  localparam int H_GAP  = 2;
  localparam int EPB    = 8 / N;
  localparam int CPL    = X_RES / N;
  localparam int BPB    = 8 * EPB;
  localparam int BEATS  = X_RES * 8 / N;
  localparam int LPER   = 1 + CPL + H_GAP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        blk_valid = 1'b0;
  logic        blk_sob = 1'b0;
  logic        blk_eob = 1'b0;
  logic        blk_sof = 1'b0;
  logic [15:0] blk_data_y = '0;
  logic [15:0] blk_data_cr = '0;
  logic [15:0] blk_data_cb = '0;
  logic        blk_ready, hdmi_v_sync, hdmi_h_sync, hdmi_data_valid;
  logic [15:0] hdmi_data_y, hdmi_data_cr, hdmi_data_cb;

  always #5 clk = ~clk;

  blocks_to_hdmi #(.N(N), .X_RES(X_RES), .Y_RES(Y_RES), .H_GAP(H_GAP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .blk_valid       (blk_valid),
    .blk_ready       (blk_ready),
    .blk_data_y      (blk_data_y),
    .blk_data_cr     (blk_data_cr),
    .blk_data_cb     (blk_data_cb),
    .blk_sob         (blk_sob),
    .blk_eob         (blk_eob),
    .blk_sof         (blk_sof),
    .hdmi_v_sync     (hdmi_v_sync),
    .hdmi_h_sync     (hdmi_h_sync),
    .hdmi_data_valid (hdmi_data_valid),
    .hdmi_data_y     (hdmi_data_y),
    .hdmi_data_cr    (hdmi_data_cr),
    .hdmi_data_cb    (hdmi_data_cb)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an image of the strip being assembled, and the raster words it must produce.
  logic [7:0]  img_y  [8][X_RES];
  logic [7:0]  img_cr [8][X_RES];
  logic [7:0]  img_cb [8][X_RES];
  int          cur_beats = 0;
  bit          cur_sof = 1'b0;
  logic [47:0] exp_q[$];
  bit          exp_sof_q[$];
  int          h_count = 0;
  int          v_count = 0;
  int          d_count = 0;
  int          line_in_strip = 0;

  task automatic model_beat(input logic [15:0] y, input logic [15:0] cr, input logic [15:0] cb, input bit sof);
    int blk, ln, el, x;
    logic [15:0] wy, wcr, wcb;
    if (sof) begin
      cur_beats = 0;
      cur_sof   = 1'b1;
    end
    blk = cur_beats / BPB;
    ln  = (cur_beats / EPB) % 8;
    el  = cur_beats % EPB;
    for (int k = 0; k < N; k++) begin
      x = blk * 8 + el * N + k;
      img_y[ln][x]  = y[(N-1-k)*8 +: 8];
      img_cr[ln][x] = cr[(N-1-k)*8 +: 8];
      img_cb[ln][x] = cb[(N-1-k)*8 +: 8];
    end
    cur_beats++;
    if (cur_beats == BEATS) begin
      for (int l = 0; l < 8; l++) begin
        for (int b = 0; b < CPL; b++) begin
          for (int k = 0; k < N; k++) begin
            wy[(N-1-k)*8 +: 8]  = img_y[l][b*N+k];
            wcr[(N-1-k)*8 +: 8] = img_cr[l][b*N+k];
            wcb[(N-1-k)*8 +: 8] = img_cb[l][b*N+k];
          end
          exp_q.push_back({wcb, wcr, wy});
        end
      end
      exp_sof_q.push_back(cur_sof);
      cur_beats = 0;
      cur_sof   = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hdmi_v_sync) begin
        v_count++;
        check("vsync_with_hsync", 64'(hdmi_h_sync), 64'(1));
      end
      if (hdmi_h_sync) begin
        h_count++;
        if (line_in_strip == 0) begin
          check("strip_expected", 64'(exp_sof_q.size() != 0), 64'(1));
          if (exp_sof_q.size() != 0) check("vsync_at_strip", 64'(hdmi_v_sync), 64'(exp_sof_q.pop_front()));
        end else begin
          check("vsync_mid_strip", 64'(hdmi_v_sync), 64'(0));
        end
        line_in_strip = (line_in_strip + 1) % 8;
      end
      if (hdmi_data_valid) begin
        d_count++;
        check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) check("pixel", 64'({hdmi_data_cb, hdmi_data_cr, hdmi_data_y}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_beat(input logic [15:0] y, input logic [15:0] cr, input logic [15:0] cb,
                           input bit sof, output int waited);
    bit ok;
    blk_valid   = 1'b1;
    blk_data_y  = y;
    blk_data_cr = cr;
    blk_data_cb = cb;
    blk_sof     = sof;
    blk_sob     = sof || (cur_beats % EPB == 0);
    blk_eob     = (cur_beats % EPB == EPB - 1);
    ok = 1'b0;
    waited = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (blk_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    check("accept_in_time", 64'(ok), 64'(1));
    if (ok) model_beat(y, cr, cb, sof);
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    blk_sof   = 1'b0;
    blk_sob   = 1'b0;
    blk_eob   = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
    repeat (20) @(negedge clk);
    check({name, "_strips_done"}, 64'(exp_sof_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pval(input int blk, input int ln, input int col);
    return 8'(blk * 64 + ln * 8 + col);
  endfunction

  typedef struct packed {
    logic en;
    logic valid;
    logic exp_ready;
  } rvec_t;

  typedef struct packed {
    logic        v;
    logic        h;
    logic        dv;
    logic [15:0] y;
  } tvec_t;

  rvec_t rv [6];
  tvec_t tv [8*LPER];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, tot_wait, hb, vb, db, l, p, x0, blk, ln, el;
    logic [15:0] y;

    rv[0] = '{1'b0, 1'b1, 1'b0};
    rv[1] = '{1'b0, 1'b1, 1'b0};
    rv[2] = '{1'b0, 1'b0, 1'b0};
    rv[3] = '{1'b1, 1'b0, 1'b1};
    rv[4] = '{1'b0, 1'b1, 1'b0};
    rv[5] = '{1'b0, 1'b1, 1'b0};
    for (int o = 0; o < 8 * LPER; o++) begin
      l  = o / LPER;
      p  = o % LPER;
      x0 = 2 * (p - 1);
      tv[o].v  = (o == 0);
      tv[o].h  = (p == 0);
      tv[o].dv = (p >= 1 && p <= CPL);
      tv[o].y  = tv[o].dv ? {pval(x0 / 8, l, x0 % 8), pval((x0 + 1) / 8, l, (x0 + 1) % 8)} : 16'h0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({hdmi_v_sync, hdmi_h_sync, hdmi_data_valid, hdmi_data_y, hdmi_data_cr, hdmi_data_cb}), 64'(0));
    check("rst_ready", 64'(blk_ready), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // en gating of blk_ready
    for (int i = 0; i < 6; i++) begin
      en        = rv[i].en;
      blk_valid = rv[i].valid;
      @(negedge clk);
      check($sformatf("en_ready[%0d]", i), 64'(blk_ready), 64'(rv[i].exp_ready));
      check($sformatf("en_no_output[%0d]", i), 64'(hdmi_data_valid), 64'(0));
      @(posedge clk);
      #1;
    end

    // Single strip with known pixel values; acceptance starts the cycle en rises
    en = 1'b1;
    for (int i = 0; i < BEATS; i++) begin
      blk = i / BPB;
      ln  = (i / EPB) % 8;
      el  = i % EPB;
      y   = {pval(blk, ln, 2 * el), pval(blk, ln, 2 * el + 1)};
      send_beat(y, y ^ 16'hA5A5, ~y, i == 0, waited);
      if (i == 0) check("en_same_cycle", 64'(waited), 64'(0));
    end
    waited = 0;
    while (!hdmi_h_sync && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("first_hsync_seen", 64'(hdmi_h_sync), 64'(1));
    for (int o = 0; o < 8 * LPER; o++) begin
      if (o > 0) @(negedge clk);
      check($sformatf("timing[%0d]", o), 64'({hdmi_v_sync, hdmi_h_sync, hdmi_data_valid}),
            64'({tv[o].v, tv[o].h, tv[o].dv}));
      if (tv[o].dv) check($sformatf("line_y[%0d]", o), 64'(hdmi_data_y), 64'(tv[o].y));
    end
    drain("single");

    // Back-to-back frame, blk_valid held high
    hb = h_count; vb = v_count; db = d_count; tot_wait = 0;
    for (int i = 0; i < 2 * BEATS; i++) begin
      send_beat(16'($urandom), 16'($urandom), 16'($urandom), i == 0, waited);
      tot_wait += waited;
    end
    check("b2b_no_stall", 64'(tot_wait), 64'(0));
    blk_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_low[%0d]", i), 64'(blk_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    drain("b2b");
    check("b2b_vsyncs", 64'(v_count - vb), 64'(1));
    check("b2b_hsyncs", 64'(h_count - hb), 64'(16));
    check("b2b_beats", 64'(d_count - db), 64'(2 * BEATS));

    // Random input gaps over four strips
    hb = h_count; vb = v_count;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < BEATS; i++) begin
        if ($urandom_range(0, 99) < 30) begin
          blk_valid = 1'b0;
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
        send_beat(16'($urandom), 16'($urandom), 16'($urandom), s == 0 && i == 0, waited);
      end
    end
    drain("random");
    check("random_vsyncs", 64'(v_count - vb), 64'(1));
    check("random_hsyncs", 64'(h_count - hb), 64'(32));

    // Mid-strip sof discards the partial strip
    hb = h_count; vb = v_count; db = d_count;
    for (int i = 0; i < 20; i++) send_beat(16'($urandom), 16'($urandom), 16'($urandom), 1'b0, waited);
    for (int i = 0; i < BEATS; i++) send_beat(16'($urandom), 16'($urandom), 16'($urandom), i == 0, waited);
    drain("midsof");
    check("midsof_vsyncs", 64'(v_count - vb), 64'(1));
    check("midsof_hsyncs", 64'(h_count - hb), 64'(8));
    check("midsof_beats", 64'(d_count - db), 64'(BEATS));

    // Reset asserted while line 3 is being output
    hb = h_count;
    for (int i = 0; i < BEATS; i++) send_beat(16'($urandom), 16'($urandom), 16'($urandom), i == 0, waited);
    waited = 0;
    while (h_count < hb + 4 && waited < 300) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("line3_reached", 64'(h_count - hb), 64'(4));
    repeat (3) @(negedge clk);
    check("line3_active", 64'(hdmi_data_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_sof_q.delete();
    line_in_strip = 0;
    cur_beats = 0;
    cur_sof = 1'b0;
    #1;
    check("midrst_outputs", 64'({hdmi_v_sync, hdmi_h_sync, hdmi_data_valid, hdmi_data_y, hdmi_data_cr, hdmi_data_cb}), 64'(0));
    repeat (2) @(negedge clk);
    check("midrst_held", 64'({hdmi_v_sync, hdmi_h_sync, hdmi_data_valid}), 64'(0));
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    hb = h_count; vb = v_count; db = d_count;
    for (int i = 0; i < BEATS; i++) send_beat(16'($urandom), 16'($urandom), 16'($urandom), i == 0, waited);
    drain("postrst");
    check("postrst_vsyncs", 64'(v_count - vb), 64'(1));
    check("postrst_hsyncs", 64'(h_count - hb), 64'(8));
    check("postrst_beats", 64'(d_count - db), 64'(BEATS));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
